// File: rtl/soc_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_lsu_pkg
// Description : Shared types and helpers for the SoC load/store initiator:
//               access-size and FSM state encodings, byte-enable generation
//               and request legality checks.
// Revision    : 1.0 - initial release
// ============================================================================
package soc_lsu_pkg;

    // Core access size, encoded exactly as the i_size request field
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } lsu_size_e;

    // Initiator FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACCESS  = 2'b01,
        ST_RD_WAIT = 2'b10,
        ST_RESP    = 2'b11
    } lsu_state_e;

    localparam int C_WORD_W = 32;
    localparam int C_BE_W   = 4;

    // Byte lanes touched by an access of the given size at byte offset ofs
    function automatic logic [C_BE_W-1:0] lsu_byte_en(input lsu_size_e size,
                                                      input logic [1:0] ofs);
        logic [C_BE_W-1:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << ofs;
            SZ_HALF: be = ofs[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Size encoding is illegal or the offset is not naturally aligned
    function automatic logic lsu_size_bad(input lsu_size_e size,
                                          input logic [1:0] ofs);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = ofs[0];
            SZ_WORD: bad = (ofs != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage : soc_lsu_pkg
`default_nettype wire

// File: rtl/soc_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : soc_lsu_align
// Description : Combinational data formatter. Store side produces byte
//               enables and lane-replicated write data; load side shifts the
//               addressed bytes down to bit 0 and sign/zero extends them.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_lsu_align
    import soc_lsu_pkg::*;
(
    input  lsu_size_e   i_size,
    input  logic [1:0]  i_ofs,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wr_data,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_shifted;

    assign o_be      = lsu_byte_en(i_size, i_ofs);
    assign w_shifted = i_rdata >> {i_ofs, 3'b000};

    // Replicate the LSB-justified store data into every lane it may land in
    always_comb begin
        o_wr_data = i_wdata;
        case (i_size)
            SZ_BYTE: o_wr_data = {4{i_wdata[7:0]}};
            SZ_HALF: o_wr_data = {2{i_wdata[15:0]}};
            default: o_wr_data = i_wdata;
        endcase
    end

    // Extend the shifted load bytes to a full word
    always_comb begin
        o_ld_data = w_shifted;
        case (i_size)
            SZ_BYTE: o_ld_data = {{24{w_shifted[7]  & ~i_unsigned}}, w_shifted[7:0]};
            SZ_HALF: o_ld_data = {{16{w_shifted[15] & ~i_unsigned}}, w_shifted[15:0]};
            default: o_ld_data = w_shifted;
        endcase
    end

endmodule : soc_lsu_align
`default_nettype wire

// File: rtl/soc_lsu_master.sv
`default_nettype none
// ============================================================================
// Module      : soc_lsu_master
// Description : Load/store initiator. Accepts one core byte/half/word request
//               at a time, issues a single word-aligned access on the SoC RAM
//               port (stalling on busy), and returns a one-cycle response with
//               aligned, extended load data or an error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_lsu_master
    import soc_lsu_pkg::*;
#(
    parameter logic [31:0] P_ADDR_BASE = 32'h1000_0000,
    parameter logic [31:0] P_ADDR_MASK = 32'hffff_f000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_valid,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [29:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic        o_mem_wr_en,
    output logic [31:0] o_mem_wr_data,
    output logic        o_mem_rd_en,
    input  logic [31:0] i_mem_rd_data,
    input  logic        i_mem_busy,
    input  logic        i_mem_ack
);

    lsu_state_e  r_state;
    lsu_state_e  w_state_nxt;

    logic        r_we;
    lsu_size_e   r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_req_err;
    logic        w_in_access;
    logic [3:0]  w_be;
    logic [31:0] w_wr_data;
    logic [31:0] w_ld_data;

    // The acknowledge is informational only; progress is governed by busy
    logic        w_unused_ack;
    assign w_unused_ack = i_mem_ack;

    assign w_accept  = (r_state == ST_IDLE) && i_req;
    assign w_req_err = lsu_size_bad(lsu_size_e'(i_size), i_addr[1:0])
                     || ((i_addr & P_ADDR_MASK) != P_ADDR_BASE);

    soc_lsu_align u_align (
        .i_size     (r_size),
        .i_ofs      (r_addr[1:0]),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rdata    (i_mem_rd_data),
        .o_be       (w_be),
        .o_wr_data  (w_wr_data),
        .o_ld_data  (w_ld_data)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        w_in_access = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_req) begin
                    w_state_nxt = w_req_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_in_access = 1'b1;
                if (!i_mem_busy) begin
                    w_state_nxt = r_we ? ST_RESP : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                o_valid     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture request fields when a request is accepted
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (w_accept) begin
            r_we       <= i_we;
            r_size     <= lsu_size_e'(i_size);
            r_unsigned <= i_unsigned;
            r_addr     <= i_addr;
            r_wdata    <= i_wdata;
        end
    end

    // Response registers update only on entry to RESP so they hold between responses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_accept && w_req_err) begin
                r_err   <= 1'b1;
                r_rdata <= '0;
            end else if ((r_state == ST_ACCESS) && !i_mem_busy && r_we) begin
                r_err   <= 1'b0;
                r_rdata <= '0;
            end else if (r_state == ST_RD_WAIT) begin
                r_err   <= 1'b0;
                r_rdata <= w_ld_data;
            end
        end
    end

    assign o_err   = r_err;
    assign o_rdata = r_rdata;

    // Memory port is quiet outside ACCESS; all fields held stable during busy
    assign o_mem_addr    = w_in_access ? r_addr[31:2] : '0;
    assign o_mem_be      = w_in_access ? w_be         : '0;
    assign o_mem_wr_en   = w_in_access &&  r_we;
    assign o_mem_rd_en   = w_in_access && !r_we;
    assign o_mem_wr_data = (w_in_access && r_we) ? w_wr_data : '0;

endmodule : soc_lsu_master
`default_nettype wire

// File: tb/tb_soc_lsu_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_lsu_master
// Description : Directed, table-driven bench for soc_lsu_master with a small
//               byte-enabled RAM model behind the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_lsu_master;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [1:0]  i_size = 2'b00;
    logic        i_unsigned = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic        o_ready, o_valid, o_err;
    logic [31:0] o_rdata;
    logic [29:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic        o_mem_wr_en, o_mem_rd_en;
    logic [31:0] o_mem_wr_data;
    logic [31:0] i_mem_rd_data = '0;
    logic        i_mem_busy = 1'b0;
    logic        i_mem_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    soc_lsu_master dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req         (i_req),
        .i_we          (i_we),
        .i_size        (i_size),
        .i_unsigned    (i_unsigned),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .o_ready       (o_ready),
        .o_valid       (o_valid),
        .o_err         (o_err),
        .o_rdata       (o_rdata),
        .o_mem_addr    (o_mem_addr),
        .o_mem_be      (o_mem_be),
        .o_mem_wr_en   (o_mem_wr_en),
        .o_mem_wr_data (o_mem_wr_data),
        .o_mem_rd_en   (o_mem_rd_en),
        .i_mem_rd_data (i_mem_rd_data),
        .i_mem_busy    (i_mem_busy),
        .i_mem_ack     (i_mem_ack)
    );

    always #5 i_clk = ~i_clk;

    // RAM model: 1 KiW, byte-enabled writes, one-cycle registered reads
    logic [31:0] mem [1024];
    always @(posedge i_clk) begin
        i_mem_ack <= (o_mem_wr_en || o_mem_rd_en) && !i_mem_busy;
        if (o_mem_wr_en && !i_mem_busy) begin
            for (int b = 0; b < 4; b++) begin
                if (o_mem_be[b]) mem[o_mem_addr[9:0]][8*b +: 8] <= o_mem_wr_data[8*b +: 8];
            end
        end
        if (o_mem_rd_en) i_mem_rd_data <= mem[o_mem_addr[9:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Observations from the most recent transaction
    int          got_lat, wr_cnt, rd_cnt;
    logic        got_err, addr_moved;
    logic [31:0] got_rdata, got_wd;
    logic [29:0] got_maddr;
    logic [3:0]  got_be;

    // Issue one request, stall the memory for 'busy' ACCESS cycles, record the response
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input int busy);
        int  left;
        bit  done;
        bit  seen;
        left = busy; done = 0; seen = 0;
        wr_cnt = 0; rd_cnt = 0; got_lat = -1; addr_moved = 0;
        got_err = 1'bx; got_rdata = 'x; got_be = '0; got_maddr = '0; got_wd = '0;
        @(negedge i_clk);
        chk("ready_before_req", {31'd0, o_ready}, 32'd1);
        i_req = 1'b1; i_we = we; i_size = sz; i_unsigned = uns; i_addr = addr; i_wdata = wd;
        @(posedge i_clk);
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge i_clk);
            i_req = 1'b0;
            if (o_mem_wr_en || o_mem_rd_en) begin
                if (seen && (o_mem_addr != got_maddr)) addr_moved = 1'b1;
                seen = 1;
                got_maddr = o_mem_addr; got_be = o_mem_be; got_wd = o_mem_wr_data;
                wr_cnt += int'(o_mem_wr_en);
                rd_cnt += int'(o_mem_rd_en);
                if (left > 0) begin
                    i_mem_busy = 1'b1;
                    left--;
                end else begin
                    i_mem_busy = 1'b0;
                end
            end else begin
                i_mem_busy = 1'b0;
            end
            if (o_valid) begin
                got_lat = k; got_err = o_err; got_rdata = o_rdata; done = 1;
            end
        end
        if (!done) $display("FAIL response_timeout: got no o_valid, expected one within 40 cycles");
        @(negedge i_clk);
        i_mem_busy = 1'b0;
        chk("valid_single_cycle", {31'd0, o_valid}, 32'd0);
        chk("ready_after_resp", {31'd0, o_ready}, 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          busy;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        int          exp_lat;
    } vec_t;

    localparam int NV = 20;
    vec_t vt [NV];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        //         we    sz     u     addr          wdata        busy err  rdata         be       wr_data       lat
        vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h1000_0004, 32'hDEADBEEF, 0, 1'b0, 32'h0,         4'b1111, 32'hDEADBEEF, 1};
        vt[1]  = '{1'b1, 2'b00, 1'b0, 32'h1000_0007, 32'h0000_00A5, 0, 1'b0, 32'h0,        4'b1000, 32'hA5A5A5A5, 1};
        vt[2]  = '{1'b0, 2'b10, 1'b0, 32'h1000_0004, 32'h0,        0, 1'b0, 32'hA5ADBEEF,  4'b1111, 32'h0,        2};
        vt[3]  = '{1'b1, 2'b10, 1'b0, 32'h1000_0010, 32'h80FF7F01, 0, 1'b0, 32'h0,         4'b1111, 32'h80FF7F01, 1};
        vt[4]  = '{1'b0, 2'b00, 1'b0, 32'h1000_0011, 32'h0,        0, 1'b0, 32'h0000007F,  4'b0010, 32'h0,        2};
        vt[5]  = '{1'b0, 2'b00, 1'b0, 32'h1000_0012, 32'h0,        0, 1'b0, 32'hFFFFFFFF,  4'b0100, 32'h0,        2};
        vt[6]  = '{1'b0, 2'b00, 1'b1, 32'h1000_0012, 32'h0,        0, 1'b0, 32'h000000FF,  4'b0100, 32'h0,        2};
        vt[7]  = '{1'b0, 2'b01, 1'b0, 32'h1000_0012, 32'h0,        0, 1'b0, 32'hFFFF80FF,  4'b1100, 32'h0,        2};
        vt[8]  = '{1'b0, 2'b01, 1'b1, 32'h1000_0010, 32'h0,        0, 1'b0, 32'h00007F01,  4'b0011, 32'h0,        2};
        vt[9]  = '{1'b0, 2'b00, 1'b0, 32'h1000_0013, 32'h0,        0, 1'b0, 32'hFFFFFF80,  4'b1000, 32'h0,        2};
        vt[10] = '{1'b1, 2'b01, 1'b0, 32'h1000_0022, 32'hFFFF1234, 0, 1'b0, 32'h0,         4'b1100, 32'h12341234, 1};
        vt[11] = '{1'b0, 2'b10, 1'b0, 32'h1000_0020, 32'h0,        0, 1'b0, 32'h12340000,  4'b1111, 32'h0,        2};
        vt[12] = '{1'b0, 2'b10, 1'b0, 32'h1000_0010, 32'h0,        3, 1'b0, 32'h80FF7F01,  4'b1111, 32'h0,        5};
        vt[13] = '{1'b0, 2'b10, 1'b0, 32'h1000_0FFC, 32'h0,        0, 1'b0, 32'h0,         4'b1111, 32'h0,        2};
        vt[14] = '{1'b0, 2'b01, 1'b0, 32'h1000_0003, 32'h0,        0, 1'b1, 32'h0,         4'b0000, 32'h0,        0};
        vt[15] = '{1'b0, 2'b10, 1'b0, 32'h1000_0002, 32'h0,        0, 1'b1, 32'h0,         4'b0000, 32'h0,        0};
        vt[16] = '{1'b0, 2'b11, 1'b0, 32'h1000_0000, 32'h0,        0, 1'b1, 32'h0,         4'b0000, 32'h0,        0};
        vt[17] = '{1'b0, 2'b10, 1'b0, 32'h2000_0000, 32'h0,        0, 1'b1, 32'h0,         4'b0000, 32'h0,        0};
        vt[18] = '{1'b1, 2'b10, 1'b0, 32'h1000_1000, 32'h12345678, 0, 1'b1, 32'h0,         4'b0000, 32'h0,        0};
        vt[19] = '{1'b1, 2'b01, 1'b0, 32'h1000_0001, 32'h0000BEEF, 0, 1'b1, 32'h0,         4'b0000, 32'h0,        0};

        // Reset state
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_ready",   {31'd0, o_ready},     32'd1);
        chk("rst_valid",   {31'd0, o_valid},     32'd0);
        chk("rst_err",     {31'd0, o_err},       32'd0);
        chk("rst_rdata",   o_rdata,              32'd0);
        chk("rst_strobes", {30'd0, o_mem_wr_en, o_mem_rd_en}, 32'd0);
        chk("rst_mem_addr", {2'd0, o_mem_addr},  32'd0);
        chk("rst_mem_be",  {28'd0, o_mem_be},    32'd0);
        i_rst = 1'b0;

        // Table-driven transactions
        for (int i = 0; i < NV; i++) begin
            do_req(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, vt[i].busy);
            chk($sformatf("v%0d_err", i), {31'd0, got_err}, {31'd0, vt[i].exp_err});
            chk($sformatf("v%0d_latency", i), got_lat, vt[i].exp_lat);
            chk($sformatf("v%0d_wr_cycles", i), wr_cnt,
                (vt[i].we && !vt[i].exp_err) ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_rd_cycles", i), rd_cnt,
                (!vt[i].we && !vt[i].exp_err) ? 32'(vt[i].busy + 1) : 32'd0);
            if (!vt[i].exp_err) begin
                chk($sformatf("v%0d_be", i), {28'd0, got_be}, {28'd0, vt[i].exp_be});
                chk($sformatf("v%0d_mem_addr", i), {2'd0, got_maddr}, {2'd0, vt[i].addr[31:2]});
                chk($sformatf("v%0d_addr_stable", i), {31'd0, addr_moved}, 32'd0);
            end
            if (vt[i].we && !vt[i].exp_err)
                chk($sformatf("v%0d_wr_data", i), got_wd, vt[i].exp_wd);
            if (!vt[i].we || vt[i].exp_err)
                chk($sformatf("v%0d_rdata", i), got_rdata, vt[i].exp_rdata);
        end

        // Load with nonzero result so the reset below has something to clear
        do_req(1'b0, 2'b10, 1'b0, 32'h1000_0004, 32'h0, 0);
        chk("pre_rst_load", got_rdata, 32'hA5ADBEEF);

        // Reset asserted while the load sits in RD_WAIT
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b0; i_size = 2'b10; i_unsigned = 1'b0;
        i_addr = 32'h1000_0010; i_wdata = '0;
        @(negedge i_clk);
        i_req = 1'b0;
        chk("mid_access_rd_en", {31'd0, o_mem_rd_en}, 32'd1);
        @(negedge i_clk);
        chk("mid_rd_wait_quiet", {31'd0, o_mem_rd_en}, 32'd0);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("midrst_ready", {31'd0, o_ready}, 32'd1);
        chk("midrst_valid", {31'd0, o_valid}, 32'd0);
        chk("midrst_rdata", o_rdata, 32'd0);
        i_rst = 1'b0;
        begin
            int vcount;
            vcount = 0;
            repeat (4) begin
                @(negedge i_clk);
                vcount += int'(o_valid);
            end
            chk("midrst_no_resp", vcount, 32'd0);
        end

        // Normal operation resumes: store then read back
        do_req(1'b1, 2'b10, 1'b0, 32'h1000_0030, 32'h0BADF00D, 0);
        chk("post_rst_store_err", {31'd0, got_err}, 32'd0);
        chk("post_rst_store_lat", got_lat, 32'd1);
        chk("post_rst_store_wr", wr_cnt, 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'h1000_0030, 32'h0, 0);
        chk("post_rst_load", got_rdata, 32'h0BADF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute backstop against a hung bench
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000, expected to finish");
        $fatal(1);
    end

endmodule : tb_soc_lsu_master
`default_nettype wire
